fetch_instr_queue: RTL

Instruction buffer between the fetch stage's first-taken-branch filter and decode. Each cycle it accepts one fetch group of `NR_INSTR` entries with per-slot valid bits, compacts the valid entries in program order, and stores them in a circular queue. It issues one instruction per cycle to decode over a valid/ready handshake. A flush from the backend or a misprediction discards all buffered instructions.

---
 rtl/fetch_instr_queue_pkg.sv | 7 +
 rtl/tortoise_pkg.sv | 24 ++
 rtl/fetch_instr_queue_if.sv | 32 +++
 rtl/fetch_group_compact.sv | 25 ++
 rtl/fetch_instr_queue.sv | 68 ++++++
 5 files changed

// File: rtl/fetch_instr_queue_pkg.sv
// fetch_instr_queue_pkg: sizing helpers for the instruction queue
//   cnt_w(n)  bits needed to hold a value in 0..n
package fetch_instr_queue_pkg;
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/tortoise_pkg.sv
// tortoise_pkg: shared fetch-side types used by the instruction queue
//   cf_t            control-flow class attached to a predicted instruction
//   predict_t       prediction info carried with each fetch entry
//   fetch_entry_t   one fetched instruction slot with its valid bit
//   INSTR_PER_FETCH slots delivered per fetch group
package tortoise_pkg;
    localparam int unsigned INSTR_PER_FETCH = 4;
    typedef enum logic [1:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JUMP,
        CF_RETURN
    } cf_t;
    typedef struct packed {
        cf_t         cf;
        logic [31:0] target;
    } predict_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        predict_t    predict;
        logic        valid;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_instr_queue_if.sv
// fetch_instr_queue_if: fetch-side push and decode-side issue bundle of the queue
//   flush_i       discard all queued entries
//   instrs_i      fetch group, per-slot valid selects stored slots
//   push_valid_i  fetch group present
//   push_ready_o  queue can take a full group
//   instr_o       head entry, .valid mirrors instr_valid_o
//   instr_valid_o queue non-empty
//   instr_ready_i decode consumes the head
//   count_o       occupied entries 0..DEPTH
interface fetch_instr_queue_if
    import tortoise_pkg::*;
#(
    parameter int unsigned NR_INSTR = INSTR_PER_FETCH,
    parameter int unsigned DEPTH    = 8
);
    logic                             flush_i;
    fetch_entry_t [NR_INSTR-1:0]      instrs_i;
    logic                             push_valid_i;
    logic                             push_ready_o;
    fetch_entry_t                     instr_o;
    logic                             instr_valid_o;
    logic                             instr_ready_i;
    logic [$clog2(DEPTH):0]           count_o;
    modport master (
        output flush_i, instrs_i, push_valid_i, instr_ready_i,
        input  push_ready_o, instr_o, instr_valid_o, count_o
    );
    modport slave (
        input  flush_i, instrs_i, push_valid_i, instr_ready_i,
        output push_ready_o, instr_o, instr_valid_o, count_o
    );
endinterface

// File: rtl/fetch_group_compact.sv
// fetch_group_compact: destination offsets and popcount for a fetch-group valid mask
//   valid_i   per-slot valid mask
//   offset_o  exclusive prefix sum of valid_i, i.e. write offset of each valid slot
//   cnt_o     number of valid slots
module fetch_group_compact
    import fetch_instr_queue_pkg::*;
#(
    parameter int unsigned NR_INSTR = 4,
    localparam int unsigned NW = cnt_w(NR_INSTR)
) (
    input  logic [NR_INSTR-1:0]         valid_i,
    output logic [NR_INSTR-1:0][NW-1:0] offset_o,
    output logic [NW-1:0]               cnt_o
);
    logic [NW-1:0] acc;
    always_comb begin
        acc = '0;
        offset_o = '0;
        for (int i = 0; i < NR_INSTR; i++) begin
            offset_o[i] = acc;
            acc = acc + NW'(valid_i[i]);
        end
        cnt_o = acc;
    end
endmodule

// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: compacting circular instruction buffer between fetch and decode
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   q       slave side of fetch_instr_queue_if (push group in, one instruction out)
module fetch_instr_queue
    import tortoise_pkg::*;
    import fetch_instr_queue_pkg::*;
#(
    parameter int unsigned NR_INSTR = INSTR_PER_FETCH,
    parameter int unsigned DEPTH    = 8
) (
    input logic                clk_i,
    input logic                rst_ni,
    fetch_instr_queue_if.slave q
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NW = cnt_w(NR_INSTR);
    fetch_entry_t                 storage_q [DEPTH];
    fetch_entry_t                 storage_d [DEPTH];
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic [NR_INSTR-1:0]          mask;
    logic [NR_INSTR-1:0][NW-1:0]  offset;
    logic [NW-1:0]                n;
    logic                         push, pop;
    always_comb begin
        mask = '0;
        for (int i = 0; i < NR_INSTR; i++) mask[i] = q.instrs_i[i].valid;
    end
    fetch_group_compact #(.NR_INSTR(NR_INSTR)) i_compact (
        .valid_i  (mask),
        .offset_o (offset),
        .cnt_o    (n)
    );
    // Ready needs room for a whole group from registered count alone; a pop this cycle gives no credit.
    assign q.push_ready_o  = count_q <= CW'(DEPTH - NR_INSTR);
    assign q.instr_valid_o = count_q != '0;
    assign q.count_o       = count_q;
    assign push = q.push_valid_i && q.push_ready_o && !q.flush_i;
    assign pop  = q.instr_valid_o && q.instr_ready_i && !q.flush_i;
    // Stale storage after a flush is hidden by forcing valid from the occupancy.
    always_comb begin
        q.instr_o       = storage_q[rd_ptr_q];
        q.instr_o.valid = q.instr_valid_o;
    end
    always_comb begin
        storage_d = storage_q;
        for (int i = 0; i < NR_INSTR; i++)
            if (push && q.instrs_i[i].valid) storage_d[wr_ptr_q + PW'(offset[i])] = q.instrs_i[i];
        rd_ptr_d = q.flush_i ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = q.flush_i ? '0 : (push ? wr_ptr_q + PW'(n) : wr_ptr_q);
        count_d  = q.flush_i ? '0 : count_q + (push ? CW'(n) : '0) - CW'(pop);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            storage_q <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            storage_q <= storage_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule
